// File: rtl/stepper_ctrl.sv
// stepper_ctrl: converts geo/gps/QR commands into counted or continuous stepper coil phases.
// Define HALF_STEP_EN for the 8-entry half-step table; the default build uses wave-drive full steps.
module stepper_ctrl #(
    parameter int W        = 8,
    parameter int STEP_DIV = 50
) (
    input  logic         PWM,
    input  logic         RST_n,
    input  logic         EN,
    input  logic         start,
    input  logic         stop,
    input  logic         QR_in,
    input  logic [W-1:0] geo_in,
    input  logic [W-1:0] gps_in,
    output logic [3:0]   M_OUT,
    output logic         ro_motor,
    output logic         dir,
    output logic         busy,
    output logic         done
);
`ifdef HALF_STEP_EN
    localparam int PH_W = 3;
    localparam logic [3:0] TBL [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                       4'b0010, 4'b0011, 4'b0001, 4'b1001};
`else
    localparam int PH_W = 2;
    localparam logic [3:0] TBL [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
`endif
    localparam int PS_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, CONT} state_t;

    state_t          state, state_n;
    logic [PH_W-1:0] phase, phase_n;
    logic [PS_W-1:0] presc, presc_n;
    logic [W-2:0]    rem, rem_n;
    logic            dir_n, done_n;
    logic [W-2:0]    geo_mag, gps_mag;
    logic            gps_sign_unused;

    assign geo_mag         = geo_in[W-2:0];
    assign gps_mag         = gps_in[W-2:0];
    // Latitude always rotates clockwise, so its sign bit carries no meaning here.
    assign gps_sign_unused = gps_in[W-1];

    always_ff @(posedge PWM or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
            phase <= '0;
            presc <= '0;
            rem   <= '0;
            dir   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            presc <= presc_n;
            rem   <= rem_n;
            dir   <= dir_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        presc_n = presc;
        rem_n   = rem;
        dir_n   = dir;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    presc_n = '0;
                    dir_n   = 1'b1;
                    if (QR_in) begin
                        state_n = CONT;
                    end else if (geo_mag != '0) begin
                        state_n = RUN;
                        dir_n   = ~geo_in[W-1];
                        rem_n   = geo_mag;
                    end else if (gps_mag != '0) begin
                        state_n = RUN;
                        rem_n   = gps_mag;
                    end else begin
                        // Zero-magnitude command completes immediately without energising coils.
                        rem_n   = '0;
                        done_n  = 1'b1;
                    end
                end
            end
            RUN, CONT: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (EN) begin
                    if (presc == PS_LAST) begin
                        presc_n = '0;
                        phase_n = dir ? phase + 1'b1 : phase - 1'b1;
                        if (state == RUN) begin
                            rem_n = rem - 1'b1;
                            if (rem == (W-1)'(1)) begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end
                        end
                    end else begin
                        presc_n = presc + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign ro_motor = busy & EN;
    assign M_OUT    = ro_motor ? TBL[phase] : 4'b0000;
endmodule
